// File: rtl/inst_fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch unit: owns the PC, keeps at most one imem read in flight, hands words to the decoder.
// Optional build macro IFU_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
//
// state | meaning
// REQ   | presenting a read of pc to instruction memory
// WAIT  | read accepted, waiting for the response
// HOLD  | instruction presented to the decoder
// STOP  | halted or faulted, no requests issued
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fetch_fault
`ifdef IFU_PERF_EN
  ,
  output logic [63:0]           perf_fetch_cnt,
  output logic [63:0]           perf_stall_cnt
`endif
);

  localparam logic [1:0] REQ  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] STOP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  kill_q, kill_d;
  logic                  fault_q, fault_d;
  logic                  live_q;

  logic req_fire, hs, misalign;

  // live_q keeps the request low while reset is held and for the release cycle
  assign imem_req_valid = live_q & (state_q == REQ) & ~halt;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_fault    = fault_q;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign hs       = inst_valid & inst_ready;
  assign misalign = (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    kill_d    = kill_q;
    fault_d   = fault_q;
    case (state_q)
      REQ: begin
        if (redirect_valid && misalign) begin
          fault_d = 1'b1;
          kill_d  = req_fire;
          state_d = STOP;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
          if (req_fire) begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end else if (halt) begin
            state_d = STOP;
          end
        end else if (req_fire) begin
          state_d = WAIT;
        end else if (halt) begin
          state_d = STOP;
        end
      end
      WAIT: begin
        if (redirect_valid && misalign) begin
          fault_d = 1'b1;
          kill_d  = ~imem_resp_valid;
          state_d = STOP;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid && misalign) begin
          fault_d = 1'b1;
          state_d = STOP;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (hs) begin
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = halt ? STOP : REQ;
        end
      end
      default: begin
        // a read killed by a faulting redirect may still land here
        if (imem_resp_valid) kill_d = 1'b0;
        if (redirect_valid && !halt && !fault_q) begin
          if (misalign) begin
            fault_d = 1'b1;
          end else begin
            pc_d    = redirect_pc;
            state_d = REQ;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ;
      pc_q      <= PC_RESET;
      inst_q    <= '0;
      inst_pc_q <= '0;
      kill_q    <= 1'b0;
      fault_q   <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      kill_q    <= kill_d;
      fault_q   <= fault_d;
      live_q    <= 1'b1;
    end
  end

`ifdef IFU_PERF_EN
  logic [63:0] fetch_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (state_q == REQ) | (state_q == WAIT) | ((state_q == HOLD) & ~inst_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (hs)    fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (stall) stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for inst_fetch_unit: memory model plus decoder-side monitor popping expected (pc, inst).
module tb_inst_fetch_unit;

  localparam logic [63:0] PC_RESET = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fetch_fault;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  inst_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fetch_fault     (fetch_fault)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model
  int          mem_lat  = 1;
  int          mem_mode = 0;
  int          pend     = 0;
  logic [63:0] pend_addr;
  logic [63:0] dead_addr = '1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == dead_addr) return 32'hDEAD_BEEF;
    if (mem_mode == 0) return 32'h0000_0013;
    return {a[23:0], 8'h13};
  endfunction

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    pend_addr       = '0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      if (!rst_n) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend_addr);
        end
      end
      #4;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        pend      = mem_lat;
        pend_addr = imem_req_addr;
      end
    end
  end

  // decoder-side scoreboard
  logic [63:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  int          hs_cyc[$];
  int          hs_total = 0;

  task automatic expect_inst(input logic [63:0] pc);
    exp_pc_q.push_back(pc);
    exp_inst_q.push_back(mem_word(pc));
  endtask

  initial begin
    logic [63:0] epc;
    logic [31:0] einst;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && inst_valid && inst_ready) begin
        hs_total++;
        hs_cyc.push_back(cyc);
        checks++;
        if (exp_pc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_inst: got pc=%h inst=%h, required no handshake", inst_pc, inst);
        end else begin
          epc   = exp_pc_q.pop_front();
          einst = exp_inst_q.pop_front();
          if (inst_pc !== epc || inst !== einst) begin
            errors++;
            $display("FAIL inst_handshake: got pc=%h inst=%h, required pc=%h inst=%h",
                     inst_pc, inst, epc, einst);
          end
        end
      end
    end
  end

  task automatic drain(input int budget, output bit ok);
    int n = 0;
    while (exp_pc_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (exp_pc_q.size() == 0);
  endtask

  task automatic wait_inst_valid(input int budget, output bit ok);
    int n = 0;
    while (!inst_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = inst_valid;
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); end
    checks++; if (imem_req_addr !== PC_RESET) begin errors++; $display("FAIL rst_req_addr: got %h, required %h", imem_req_addr, PC_RESET); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b, required 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h, required 0", inst); end
    checks++; if (inst_pc !== 64'h0) begin errors++; $display("FAIL rst_inst_pc: got %h, required 0", inst_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b, required 0", fetch_fault); end
`ifdef IFU_PERF_EN
    checks++; if (perf_fetch_cnt !== 64'h0) begin errors++; $display("FAIL rst_perf_fetch: got %0d, required 0", perf_fetch_cnt); end
    checks++; if (perf_stall_cnt !== 64'h0) begin errors++; $display("FAIL rst_perf_stall: got %0d, required 0", perf_stall_cnt); end
`endif
  endtask

  task automatic test_stream;
    bit ok;
    mem_mode       = 0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    expect_inst(PC_RESET);
    expect_inst(PC_RESET + 64'h4);
    expect_inst(PC_RESET + 64'h8);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_RESET) begin
      errors++;
      $display("FAIL first_req: got valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, PC_RESET);
    end
    drain(40, ok);
    imem_req_ready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stream_drain: got %0d pending, required 0", exp_pc_q.size()); end
    checks++;
    if (hs_cyc.size() != 3) begin
      errors++;
      $display("FAIL stream_count: got %0d handshakes, required 3", hs_cyc.size());
    end else begin
      checks++;
      if (hs_cyc[1] - hs_cyc[0] != 3 || hs_cyc[2] - hs_cyc[1] != 3) begin
        errors++;
        $display("FAIL stream_rate: got gaps %0d,%0d cycles, required 3,3", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
      end
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_RESET + 64'hC) begin
      errors++;
      $display("FAIL stream_next_req: got valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, PC_RESET + 64'hC);
    end
  endtask

  task automatic test_req_stall;
    bit stable = 1'b1;
`ifdef IFU_PERF_EN
    logic [63:0] stall0 = perf_stall_cnt;
`endif
    mem_mode = 1;
    repeat (4) begin
      @(negedge clk);
      if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_RESET + 64'hC) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL req_stall_addr: got valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, PC_RESET + 64'hC);
    end
`ifdef IFU_PERF_EN
    checks++;
    if (perf_stall_cnt < stall0 + 64'd4) begin
      errors++;
      $display("FAIL perf_stall: got %0d, required at least %0d", perf_stall_cnt, stall0 + 64'd4);
    end
`endif
  endtask

  task automatic test_backpressure;
    bit ok;
    bit stable = 1'b1;
    expect_inst(PC_RESET + 64'hC);
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    wait_inst_valid(20, ok);
    imem_req_ready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_wait_valid: got inst_valid=%b, required 1", inst_valid); end
    for (int i = 0; i < 5; i++) begin
      if (inst_valid !== 1'b1 || inst !== 32'h0000_0C13 || inst_pc !== PC_RESET + 64'hC || imem_req_valid !== 1'b0)
        stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold_stable: got valid=%b inst=%h pc=%h req=%b, required 1 00000c13 %h 0",
               inst_valid, inst, inst_pc, imem_req_valid, PC_RESET + 64'hC);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_RESET + 64'h10 || exp_pc_q.size() != 0) begin
      errors++;
      $display("FAIL bp_release: got valid=%b addr=%h pending=%0d, required 1 %h 0",
               imem_req_valid, imem_req_addr, exp_pc_q.size(), PC_RESET + 64'h10);
    end
  endtask

  task automatic test_redirect_wait;
    bit ok;
    int n = 0;
    int hs0 = hs_total;
    dead_addr      = PC_RESET + 64'h10;
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    expect_inst(PC_RESET + 64'h100);
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_in_wait: got req=%b inst_valid=%b, required 0 0", imem_req_valid, inst_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = PC_RESET + 64'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    mem_lat = 1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_RESET + 64'h100) begin
      errors++;
      $display("FAIL rw_next_addr: got valid=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, PC_RESET + 64'h100);
    end
    drain(30, ok);
    imem_req_ready = 1'b0;
    dead_addr      = '1;
    checks++;
    if (!ok || hs_total != hs0 + 1) begin
      errors++;
      $display("FAIL rw_delivery: got %0d handshakes %0d pending, required 1 and 0", hs_total - hs0, exp_pc_q.size());
    end
  endtask

  task automatic test_halt;
    bit ok;
    bit quiet = 1'b1;
    expect_inst(PC_RESET + 64'h104);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    wait_inst_valid(20, ok);
    halt = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL halt_wait_valid: got inst_valid=%b, required 1", inst_valid); end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== PC_RESET + 64'h108) begin
      errors++;
      $display("FAIL halt_stop: got req=%b inst_valid=%b pc=%h, required 0 0 %h",
               imem_req_valid, inst_valid, imem_req_addr, PC_RESET + 64'h108);
    end
    repeat (4) begin
      @(negedge clk);
      if (imem_req_valid !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL halt_quiet: got req_valid=1 while halted, required 0"); end
    expect_inst(PC_RESET + 64'h200);
    halt           = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = PC_RESET + 64'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_RESET + 64'h200) begin
      errors++;
      $display("FAIL halt_resume: got valid=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, PC_RESET + 64'h200);
    end
    drain(30, ok);
    imem_req_ready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL halt_drain: got %0d pending, required 0", exp_pc_q.size()); end
  endtask

  task automatic test_misaligned;
    bit sticky = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = PC_RESET + 64'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_fault: got fault=%b req=%b, required 1 0", fetch_fault, imem_req_valid);
    end
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = PC_RESET + 64'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (5) begin
      if (imem_req_valid !== 1'b0 || fetch_fault !== 1'b1) sticky = 1'b0;
      @(negedge clk);
    end
    checks++; if (!sticky) begin errors++; $display("FAIL mis_sticky: got req=%b fault=%b, required 0 1", imem_req_valid, fetch_fault); end
`ifdef IFU_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 64'(hs_total)) begin
      errors++;
      $display("FAIL perf_fetch: got %0d, required %0d", perf_fetch_cnt, hs_total);
    end
`endif
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_reset_clear: got fault=%b req=%b, required 0 0", fetch_fault, imem_req_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_RESET) begin
      errors++;
      $display("FAIL mis_restart: got valid=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, PC_RESET);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_req_stall();
    test_backpressure();
    test_redirect_wait();
    test_halt();
    test_misaligned();
    checks++;
    if (exp_pc_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d expected instructions never seen, required 0", exp_pc_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
